mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences the single unified memory port shared by the pipeline's instruction fetch (IF) and data access (MEM) stages. Accepts level requests from both sides, issues one access at a time to memory, captures results, and drives the pipeline stall until every active request of the current cycle has completed. Sits between the pipelined datapath / control unit and the external memory model; the datapath freezes its latches and PC while `stall` is high.

## Interface
- `WORD_W`, 16: address and data width.
- `MAX_WAIT`, 15: memory cycles tolerated per access before `timeout_err` sets; range 1..255.
---
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `i_req`  in  1  IF wants a fetch; level, held until `pipe_advance`.
- `i_addr`  in  WORD_W  fetch address (PC); stable while `i_req`.
- `d_req`  in  1  MEM wants a data access; level.
- `d_we`  in  1  1 = store, 0 = load; stable while `d_req`.
- `d_addr`  in  WORD_W  data address.
- `d_wdata`  in  WORD_W  store data.
- `pipe_advance`  in  1  pipeline latches update this cycle.
- `i_rdata`  out  WORD_W  fetched instruction; valid while `i_done`.
- `d_rdata`  out  WORD_W  load data; valid while `d_done`.
- `i_done`  out  1  fetch for current instruction complete.
- `d_done`  out  1  data access for current instruction complete.
- `stall`  out  1  `(i_req & !i_done) | (d_req & !d_done)`; combinational from registered flags.
- `mem_req`  out  1  access in flight to memory.
- `mem_we`  out  1  access is a write.
- `mem_addr`  out  WORD_W  memory address.
- `mem_wdata`  out  WORD_W  memory write data.
- `mem_ready`  in  1  single-cycle completion pulse from memory.
- `mem_rdata`  in  WORD_W  read data, valid with `mem_ready`.
- `timeout_err`  out  1  sticky; an access exceeded `MAX_WAIT`.

## Operation
- FSM states: IDLE, D_BUSY, I_BUSY.
- IDLE: if `d_req & !d_done` → D_BUSY; else if `i_req & !i_done` → I_BUSY; else stay. D wins ties (older instruction).
- On entry to a BUSY state, register `mem_req=1`, `mem_we` (`d_we` for D, 0 for I), `mem_addr`, `mem_wdata` (0 for I); hold all stable until `mem_ready`.
- BUSY + `mem_ready`: drop `mem_req`; set matching done flag; for loads/fetches capture `mem_rdata` into `d_rdata`/`i_rdata`; store leaves `d_rdata` unchanged; → IDLE.
- `pipe_advance` honoured only when `stall==0`: clears `i_done`, `d_done`. Ignored while `stall==1`.
- `mem_ready` in IDLE is ignored (stray/late response).
- Watchdog: counter cleared on BUSY entry, increments each BUSY cycle without `mem_ready`; reaching `MAX_WAIT` sets `timeout_err` (sticky until reset); access continues waiting, no abort.
- Request dropped mid-access (requester violates hold rule): access completes normally, done flag still set.
- Reset values: state IDLE, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `i_rdata=0`, `d_rdata=0`, `i_done=0`, `d_done=0`, `timeout_err=0`, wait counter 0. Reset mid-access abandons it; a later `mem_ready` is ignored.

## Timing
- Request seen in IDLE at edge t → `mem_req` high from t+1.
- `mem_ready` sampled at edge k → `mem_req` low, done flag and rdata valid from k+1; FSM IDLE at k+1; next access can issue `mem_req` at k+2.
- Minimum latency with 1-cycle memory: request at t, done at t+2; D then I back-to-back: I done at t+4.
- `stall` falls the same cycle the last needed done flag rises; `pipe_advance` may be asserted that cycle.
- Watchdog: `timeout_err` rises at the edge ending the `MAX_WAIT`-th BUSY cycle without `mem_ready`.

## Structure
- Shared package `mem_arb_pkg`: state enum (IDLE, D_BUSY, I_BUSY), `WORD_W` default, requester-select constants.
- One sub-module: `mem_wait_timer` (clear/enable/limit → saturating count, `expired` pulse), reusable for other multi-cycle handshakes.
- Top holds FSM, request/response registers, done flags.

## Test plan
- Fetch only: `i_req=1`, `i_addr=0x0010`, memory returns `0x6A05` after 2 cycles → `i_rdata=0x6A05`, `i_done=1`, `stall` falls; `pipe_advance` clears `i_done`.
- Simultaneous: `i_req`/`d_req` (load, `d_addr=0x0040`→`0x1234`) same cycle → D issued first, `d_rdata=0x1234`; then fetch issued; `stall` falls only after both done.
- Store: `d_we=1`, `d_addr=0x0041`, `d_wdata=0xBEEF` → `mem_we=1`, `mem_wdata=0xBEEF` held until `mem_ready`; `d_rdata` unchanged.
- Timeout: `MAX_WAIT=3`, memory silent 5 cycles → `timeout_err=1` after 3rd BUSY cycle, `mem_req` still held; late `mem_ready` completes access; error stays set.
- Reset mid-access: `reset` during D_BUSY, then `mem_ready` → all outputs at reset values, response ignored, no done flag.
- `pipe_advance` while `stall=1` → done flags unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package mem_arb_pkg;

    // Default address/data width of the pipeline memory port.
    localparam int unsigned DefaultWordW = 16;

    // Width of the wait timer; wide enough for a limit of 255.
    localparam int unsigned TimerW = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDBusy = 2'd1,
        StIBusy = 2'd2
    } arb_state_e;

    // Which requester owns the access being issued.
    typedef enum logic {
        SelD = 1'b0,
        SelI = 1'b1
    } req_sel_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the shared memory port.
// slave: the arbiter's view; master: the pipeline plus memory model.
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
    parameter int unsigned WORD_W = DefaultWordW
) ();

    logic              i_req;
    logic [WORD_W-1:0] i_addr;
    logic              d_req;
    logic              d_we;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              pipe_advance;
    logic [WORD_W-1:0] i_rdata;
    logic [WORD_W-1:0] d_rdata;
    logic              i_done;
    logic              d_done;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_rdata;
    logic              timeout_err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, pipe_advance, mem_ready, mem_rdata,
        output i_rdata, d_rdata, i_done, d_done, stall, mem_req, mem_we, mem_addr, mem_wdata,
        output timeout_err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, pipe_advance, mem_ready, mem_rdata,
        input  i_rdata, d_rdata, i_done, d_done, stall, mem_req, mem_we, mem_addr, mem_wdata,
        input  timeout_err
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for multi-cycle handshakes. expired_o pulses on
// the enabled cycle whose count step reaches limit_i; the count then holds.
module mem_wait_timer import mem_arb_pkg::*; #(
    parameter int unsigned CountW = TimerW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [CountW-1:0] limit_i,
    output logic [CountW-1:0] count_o,
    output logic              expired_o
);

    logic [CountW-1:0] count_q, count_d;
    logic [CountW:0]   count_inc;

    assign count_inc = {1'b0, count_q} + {{CountW{1'b0}}, 1'b1};
    assign count_o   = count_q;

    // Next count: clear wins, otherwise step while enabled and below the limit.
    always_comb begin
        count_d   = count_q;
        expired_o = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != limit_i)) begin
            count_d   = count_inc[CountW-1:0];
            expired_o = (count_inc == {1'b0, limit_i});
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences the single memory port between instruction fetch (IF) and data
// access (MEM). Data wins ties since it belongs to the older instruction.
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int unsigned WORD_W   = DefaultWordW,
    parameter int unsigned MAX_WAIT = 15
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [TimerW-1:0] WaitLimit = TimerW'(MAX_WAIT);

    arb_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORD_W-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              timeout_err_q, timeout_err_d;
    logic              stall;
    logic              busy;
    logic              issue;
    req_sel_e          sel;
    logic              timer_expired;
    logic [TimerW-1:0] wait_count;

    assign stall = (bus.i_req & ~i_done_q) | (bus.d_req & ~d_done_q);
    assign busy  = (state_q != StIdle);

    // Watchdog: held clear in IDLE so each access starts from zero.
    mem_wait_timer #(
        .CountW (TimerW)
    ) u_wait_timer (
        .clk_i     (clk),
        .rst_i     (reset),
        .clear_i   (~busy),
        .enable_i  (busy & ~bus.mem_ready),
        .limit_i   (WaitLimit),
        .count_o   (wait_count),
        .expired_o (timer_expired)
    );

    // Next-state: done-flag release, request issue and response capture.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        i_done_d      = i_done_q;
        d_done_d      = d_done_q;
        timeout_err_d = timeout_err_q | timer_expired;
        issue         = 1'b0;
        sel           = SelD;

        // The pipeline may only retire its done flags once nothing is stalling.
        if (bus.pipe_advance && !stall) begin
            i_done_d = 1'b0;
            d_done_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.d_req && !d_done_q) begin
                    issue   = 1'b1;
                    sel     = SelD;
                    state_d = StDBusy;
                end else if (bus.i_req && !i_done_q) begin
                    issue   = 1'b1;
                    sel     = SelI;
                    state_d = StIBusy;
                end
            end
            StDBusy: begin
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                    state_d = StIdle;
                end
            end
            StIBusy: begin
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    i_done_d  = 1'b1;
                    i_rdata_d = bus.mem_rdata;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            mem_req_d   = 1'b1;
            mem_we_d    = (sel == SelD) ? bus.d_we : 1'b0;
            mem_addr_d  = (sel == SelD) ? bus.d_addr : bus.i_addr;
            mem_wdata_d = (sel == SelD) ? bus.d_wdata : '0;
        end
    end

    // State and request/response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            i_done_q      <= i_done_d;
            d_done_q      <= d_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // The wait count saturates at the limit and never runs past it.
    assert property (@(posedge clk) disable iff (reset) wait_count <= WaitLimit);

    assign bus.stall       = stall;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.i_rdata     = i_rdata_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.i_done      = i_done_q;
    assign bus.d_done      = d_done_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a hand-driven memory response.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_port_arbiter_if #(.WORD_W(16)) bus ();

    mem_port_arbiter #(
        .WORD_W   (16),
        .MAX_WAIT (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reqs();
        bus.pipe_advance = 1'b1;
        step();
        bus.pipe_advance = 1'b0;
        bus.i_req        = 1'b0;
        bus.d_req        = 1'b0;
        bus.d_we         = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.i_req        = 1'b0;
        bus.i_addr       = 16'h0;
        bus.d_req        = 1'b0;
        bus.d_we         = 1'b0;
        bus.d_addr       = 16'h0;
        bus.d_wdata      = 16'h0;
        bus.pipe_advance = 1'b0;
        bus.mem_ready    = 1'b0;
        bus.mem_rdata    = 16'h0;
        step();
        step();
        check("rst_mem_req", 16'(bus.mem_req), 16'h0);
        check("rst_mem_addr", bus.mem_addr, 16'h0);
        check("rst_i_done", 16'(bus.i_done), 16'h0);
        check("rst_d_done", 16'(bus.d_done), 16'h0);
        check("rst_stall", 16'(bus.stall), 16'h0);
        check("rst_timeout", 16'(bus.timeout_err), 16'h0);
        reset = 1'b0;

        // Fetch only, memory answers on the second busy cycle.
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0010;
        step();
        check("f_mem_req", 16'(bus.mem_req), 16'h1);
        check("f_mem_addr", bus.mem_addr, 16'h0010);
        check("f_mem_we", 16'(bus.mem_we), 16'h0);
        check("f_stall", 16'(bus.stall), 16'h1);
        step();
        check("f_wait_req", 16'(bus.mem_req), 16'h1);
        check("f_wait_done", 16'(bus.i_done), 16'h0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h6A05;
        step();
        bus.mem_ready = 1'b0;
        check("f_i_done", 16'(bus.i_done), 16'h1);
        check("f_i_rdata", bus.i_rdata, 16'h6A05);
        check("f_req_drop", 16'(bus.mem_req), 16'h0);
        check("f_stall_fall", 16'(bus.stall), 16'h0);
        release_reqs();
        check("f_adv_clear", 16'(bus.i_done), 16'h0);
        step();
        check("f_no_reissue", 16'(bus.mem_req), 16'h0);

        // Simultaneous requests: data first, then fetch.
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0020;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0040;
        step();
        check("s_d_first_addr", bus.mem_addr, 16'h0040);
        check("s_d_first_we", 16'(bus.mem_we), 16'h0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h1234;
        step();
        bus.mem_ready = 1'b0;
        check("s_d_done", 16'(bus.d_done), 16'h1);
        check("s_d_rdata", bus.d_rdata, 16'h1234);
        check("s_still_stall", 16'(bus.stall), 16'h1);
        check("s_gap_req", 16'(bus.mem_req), 16'h0);
        // Advance request while stalled must be ignored.
        bus.pipe_advance = 1'b1;
        step();
        bus.pipe_advance = 1'b0;
        check("s_adv_ignored", 16'(bus.d_done), 16'h1);
        check("s_i_addr", bus.mem_addr, 16'h0020);
        check("s_i_req", 16'(bus.mem_req), 16'h1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hA5A5;
        step();
        bus.mem_ready = 1'b0;
        check("s_i_done", 16'(bus.i_done), 16'h1);
        check("s_i_rdata", bus.i_rdata, 16'hA5A5);
        check("s_stall_fall", 16'(bus.stall), 16'h0);
        release_reqs();
        check("s_clear_i", 16'(bus.i_done), 16'h0);
        check("s_clear_d", 16'(bus.d_done), 16'h0);

        // Store: write fields held until ready, load data untouched.
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0041;
        bus.d_wdata = 16'hBEEF;
        step();
        check("w_mem_we", 16'(bus.mem_we), 16'h1);
        check("w_mem_wdata", bus.mem_wdata, 16'hBEEF);
        check("w_mem_addr", bus.mem_addr, 16'h0041);
        step();
        check("w_hold_we", 16'(bus.mem_we), 16'h1);
        check("w_hold_wdata", bus.mem_wdata, 16'hBEEF);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hFFFF;
        step();
        bus.mem_ready = 1'b0;
        check("w_d_done", 16'(bus.d_done), 16'h1);
        check("w_d_rdata_kept", bus.d_rdata, 16'h1234);
        check("w_no_timeout", 16'(bus.timeout_err), 16'h0);
        release_reqs();

        // Timeout: silent memory for five busy cycles with MAX_WAIT=3.
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0050;
        step();
        check("t_entry_req", 16'(bus.mem_req), 16'h1);
        step();
        step();
        check("t_before", 16'(bus.timeout_err), 16'h0);
        step();
        check("t_set", 16'(bus.timeout_err), 16'h1);
        check("t_req_held", 16'(bus.mem_req), 16'h1);
        step();
        step();
        check("t_sticky", 16'(bus.timeout_err), 16'h1);
        check("t_still_wait", 16'(bus.mem_req), 16'h1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h7777;
        step();
        bus.mem_ready = 1'b0;
        check("t_late_done", 16'(bus.d_done), 16'h1);
        check("t_late_rdata", bus.d_rdata, 16'h7777);
        check("t_err_kept", 16'(bus.timeout_err), 16'h1);
        release_reqs();

        // Reset during a data access, then a stray response.
        bus.d_req  = 1'b1;
        bus.d_addr = 16'h0060;
        step();
        check("r_busy_req", 16'(bus.mem_req), 16'h1);
        reset = 1'b1;
        step();
        reset         = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h9999;
        step();
        bus.mem_ready = 1'b0;
        check("r_mem_req", 16'(bus.mem_req), 16'h0);
        check("r_mem_addr", bus.mem_addr, 16'h0);
        check("r_d_done", 16'(bus.d_done), 16'h0);
        check("r_d_rdata", bus.d_rdata, 16'h0);
        check("r_i_rdata", bus.i_rdata, 16'h0);
        check("r_timeout", 16'(bus.timeout_err), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
